// File: rtl/mem_pkg.sv
// Shared definitions for the cache-side backing memory: FSM states and word/latency defaults.
package mem_pkg;
  typedef enum logic {IDLE, WAIT} state_t;

  localparam int MEM_WORD_W      = 32;
  localparam int MEM_DEF_LATENCY = 4;
endpackage

// File: rtl/ram_storage.sv
// DEPTH x 32 single-port array: synchronous write, asynchronous read at the same index.
module ram_storage
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         idx,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset; unwritten words read back as whatever is stored.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/main_memory_responder.sv
// RAM-side responder for the cache: fixed-latency word memory with abortable accesses
// and completed read/write counters.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = MEM_DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MEM_WORD_W-1:0] data,
  input  logic [31:0]           addr,
  input  logic                  wr,
  output logic                  response,
  output logic [MEM_WORD_W-1:0] out,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  state_t                state;
  logic [7:0]            cnt;
  logic [MEM_WORD_W-1:0] data_q;
  logic [31:0]           addr_q;
  logic                  wr_q;
  logic                  change;
  logic                  commit;
  logic                  ram_we;
  logic [MEM_WORD_W-1:0] ram_rdata;

  assign change = ({data, addr, wr} != {data_q, addr_q, wr_q});
  // A change on the final WAIT edge wins over the commit, so the access is dropped.
  assign commit = (state == WAIT) && !change && (cnt == 8'd0);
  assign ram_we = commit && wr_q;

  ram_storage #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (addr_q[AW-1:0]),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      data_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      response <= 1'b1;
      out      <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (change) begin
        state    <= WAIT;
        data_q   <= data;
        addr_q   <= addr;
        wr_q     <= wr;
        cnt      <= 8'(LATENCY - 1);
        response <= 1'b0;
      end else if (state == WAIT) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          state    <= IDLE;
          response <= 1'b1;
          if (wr_q) begin
            wr_cnt <= wr_cnt + 32'd1;
          end else begin
            out    <= ram_rdata;
            rd_cnt <= rd_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: timing of the response pulse, read-back,
// aliasing, abort and reset-during-access behaviour.
module tb_main_memory_responder;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks;
  int n_fail;

  main_memory_responder #(
    .DEPTH  (1024),
    .AW     (10),
    .LATENCY(L)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .addr    (addr),
    .wr      (wr),
    .response(response),
    .out     (out),
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs were changed before edge k; expect response low after edges k..k+L-1, high after k+L.
  task automatic wait_access(input string tag);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      check_eq({tag, "_busy"}, {31'd0, response}, 32'd0);
    end
    @(negedge clk);
    check_eq({tag, "_done"}, {31'd0, response}, 32'd1);
  endtask

  task automatic issue(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    wr   = w;
    addr = a;
    data = d;
    wait_access(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    data     = '0;
    addr     = '0;
    wr       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: zero inputs match the cleared latches, so no request.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_resp", {31'd0, response}, 32'd1);
    end
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_rd_cnt", rd_cnt, 32'd0);
    check_eq("rst_wr_cnt", wr_cnt, 32'd0);

    issue("wr5", 1'b1, 32'h5, 32'hDEADBEEF);
    check_eq("wr5_wr_cnt", wr_cnt, 32'd1);
    check_eq("wr5_rd_cnt", rd_cnt, 32'd0);
    check_eq("wr5_out", out, 32'd0);

    issue("rd5", 1'b0, 32'h5, 32'hDEADBEEF);
    check_eq("rd5_out", out, 32'hDEADBEEF);
    check_eq("rd5_rd_cnt", rd_cnt, 32'd1);

    // Same inputs held: no new request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_resp", {31'd0, response}, 32'd1);
    end
    check_eq("hold_rd_cnt", rd_cnt, 32'd1);

    issue("wr405", 1'b1, 32'h405, 32'h12345678);
    check_eq("wr405_wr_cnt", wr_cnt, 32'd2);
    issue("rd5b", 1'b0, 32'h5, 32'h12345678);
    check_eq("alias_out", out, 32'h12345678);
    check_eq("alias_rd_cnt", rd_cnt, 32'd2);

    issue("wr7", 1'b1, 32'h7, 32'h11111111);
    check_eq("wr7_wr_cnt", wr_cnt, 32'd3);

    // Abort: start writing 0x7, redirect to 0x8 two cycles in.
    wr   = 1'b1;
    addr = 32'h7;
    data = 32'hAAAA0000;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_busy0", {31'd0, response}, 32'd0);
    end
    addr = 32'h8;
    wait_access("abort");
    check_eq("abort_wr_cnt", wr_cnt, 32'd4);
    issue("rd7", 1'b0, 32'h7, 32'h0);
    check_eq("abort_word7", out, 32'h11111111);
    issue("rd8", 1'b0, 32'h8, 32'h0);
    check_eq("abort_word8", out, 32'hAAAA0000);
    check_eq("abort_rd_cnt", rd_cnt, 32'd4);

    issue("wr9", 1'b1, 32'h9, 32'h55555555);
    check_eq("wr9_wr_cnt", wr_cnt, 32'd5);

    // Reset in the middle of a write to 0x9.
    wr   = 1'b1;
    addr = 32'h9;
    data = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, response}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_resp", {31'd0, response}, 32'd1);
    check_eq("midrst_rd_cnt", rd_cnt, 32'd0);
    check_eq("midrst_wr_cnt", wr_cnt, 32'd0);
    check_eq("midrst_out", out, 32'd0);
    wr   = 1'b0;
    data = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    // Latches are zero, so the held read of 0x9 is a fresh request.
    wait_access("post_rst");
    check_eq("post_rst_out", out, 32'h55555555);
    check_eq("post_rst_rd_cnt", rd_cnt, 32'd1);
    check_eq("post_rst_wr_cnt", wr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
